tau_gemm_host: RTL
==================

// Module: tau_gemm_host
// PURPOSE
// - Host-side initiator/drain for the tau GEMM multiplier array.
// - Assembles the A and B operand matrices from one valid/ready element stream, then issues a one-cycle start.
// - Captures the DIM x DIM result when the multiplier signals finished, then streams results out on valid/ready.
// - Sits between the system stream fabric and the multiplier's in0/in1/in_valid/out/finished pins.
// PARAMETERS
// - DIM       16         matrix dimension (square)
// - WIDTH     8          operand element width
// - OUT_BITS  2*WIDTH    result element width
// PORTS
// - clk           in   1                     clock
// - reset_n       in   1                     reset, asynchronous, active-low
// - s_valid       in   1                     operand element valid
// - s_ready       out  1                     operand element accepted when s_valid & s_ready
// - s_data        in   WIDTH                 operand element, row-major: A first, then B
// - s_last        in   1                     final B element marker (used only with TAU_GEMM_HOST_LAST_CHK_EN)
// - m_valid       out  1                     result element valid
// - m_ready       in   1                     result element consumed when m_valid & m_ready
// - m_data        out  OUT_BITS              result element, row-major
// - m_last        out  1                     high on result element [DIM-1][DIM-1]
// - mat_a         out  DIM*DIM*WIDTH         packed [DIM][DIM][WIDTH] to multiplier in0
// - mat_b         out  DIM*DIM*WIDTH         packed [DIM][DIM][WIDTH] to multiplier in1
// - mul_valid     out  1                     one-cycle start pulse to multiplier in_valid
// - mul_out       in   DIM*DIM*OUT_BITS      multiplier result
// - mul_finished  in   1                     multiplier done pulse
// - busy          out  1                     high in every state except LOAD_A with idx==0
// - err           out  1                     sticky framing error; cleared only by reset
// BEHAVIOUR
// - Reset: state LOAD_A, idx=0. s_ready=0 during reset, 1 from the first clock after release. m_valid=0, m_data=0, m_last=0, mul_valid=0, err=0. mat_a, mat_b and the result register are all zero.
// - Index idx is $clog2(DIM*DIM) bits. Element k maps to row k/DIM, col k%DIM. idx wraps to 0 after DIM*DIM-1.
// - LOAD_A: s_ready=1. On each accepted beat, mat_a[r][c] <= s_data and idx++. When the beat at idx==DIM*DIM-1 is accepted, go to LOAD_B.
// - LOAD_B: s_ready=1. Fills mat_b the same way. When the beat at idx==DIM*DIM-1 is accepted, go to ISSUE.
// - ISSUE (1 cycle): mul_valid=1, s_ready=0, then go to WAIT. mul_valid rises exactly 1 cycle after the final B beat is accepted.
// - WAIT: s_ready=0. On mul_finished, the result register <= mul_out and the FSM goes to DRAIN. mul_finished in any other state is ignored.
// - DRAIN: m_valid=1 from the cycle after capture. m_data = res[r][c] at idx. On each handshake, idx++.
// - DRAIN hold rule: m_data and m_last stay stable while m_valid & !m_ready.
// - DRAIN exit: when the last result (m_last=1) is handshaken, m_valid drops next cycle and the FSM goes to LOAD_A with s_ready=1.
// - No back-to-back overlap: operand loading never runs concurrently with DRAIN.
// - mat_a and mat_b hold their values from ISSUE until they are overwritten in the next LOAD_A/LOAD_B.
// - Reset mid-operation: an immediate return to reset values. Partial frames and captured results are discarded.
// CONFIGURATION
// - TAU_GEMM_HOST_LAST_CHK_EN defined: s_last is checked on every accepted beat.
//   - s_last=1 before the final B beat, or s_last=0 on the final B beat, sets err=1.
//   - After the error, the frame is discarded: idx=0, state LOAD_A, no mul_valid pulse.
// - TAU_GEMM_HOST_LAST_CHK_EN undefined: s_last is ignored, err is tied to 0, and frames are counted purely by idx.
// STRUCTURE
// - tau_gemm_pkg holds:
//   - state enum {LOAD_A, LOAD_B, ISSUE, WAIT, DRAIN}
//   - function idx_w(DIM) = $clog2(DIM*DIM)
//   - row/col split helper functions
// - One sub-module, tau_gemm_idx_cnt: a wrapping row/col counter with an inc input and a last output. It is instantiated once and shared by the load and drain phases.
// TESTING (DIM=2, WIDTH=8; bench multiplier model returns A*B with mul_finished 20 cycles after mul_valid)
// - Reset: hold reset_n=0 -> s_ready=0, m_valid=0, err=0, busy=0; one clock after release, s_ready=1.
// - Stream 1,2,3,4,5,6,7,8 -> mul_valid pulses 1 cycle after beat 8, mat_a=[[1,2],[3,4]], mat_b=[[5,6],[7,8]]; outputs 19,22,43,50, m_last on 50.
// - Toggle m_ready 1/0 every cycle in DRAIN -> each m_data is held while stalled, sequence is unchanged, no duplicates.
// - Gap s_valid randomly, and pulse mul_finished spuriously in LOAD_B -> capture is ignored and results are still correct.
// - With LAST_CHK_EN: s_last=1 on beat 3 -> err=1, no mul_valid; the next clean frame computes correctly and err stays 1.
// - Drop reset_n mid-DRAIN after 2 results -> all outputs return to reset values; a new frame streams normally.

Source files
------------

// File: rtl/tau_gemm_pkg.sv
// Shared types and index helpers for the tau GEMM host: FSM state encoding,
// flat-index width and row/column split of a row-major DIM x DIM element index.
package tau_gemm_pkg;

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      ISSUE,
      WAIT,
      DRAIN
   } state_t;

   function automatic int idx_w(input int dim);
      return $clog2(dim * dim);
   endfunction

   function automatic int rc_w(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

   function automatic int row_of(input int k, input int dim);
      return k / dim;
   endfunction

   function automatic int col_of(input int k, input int dim);
      return k % dim;
   endfunction

endpackage

// File: rtl/tau_gemm_idx_cnt.sv
// Wrapping row-major element counter shared by the operand load and result
// drain phases; last flags element [DIM-1][DIM-1].
module tau_gemm_idx_cnt
   import tau_gemm_pkg::*;
#(
   parameter  int DIM = 16,
   localparam int IW  = idx_w(DIM),
   localparam int RW  = rc_w(DIM)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          inc,
   output logic [IW-1:0] idx,
   output logic [RW-1:0] row,
   output logic [RW-1:0] col,
   output logic          last
);

   localparam logic [IW-1:0] MAX_IDX = IW'(DIM * DIM - 1);

   logic [IW-1:0] idx_q;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q <= '0;
      end else if (clr) begin
         idx_q <= '0;
      end else if (inc) begin
         idx_q <= (idx_q == MAX_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   assign idx  = idx_q;
   assign row  = RW'(row_of(int'(idx_q), DIM));
   assign col  = RW'(col_of(int'(idx_q), DIM));
   assign last = (idx_q == MAX_IDX);

endmodule

// File: rtl/tau_gemm_host.sv
// Host initiator/drain for the tau GEMM array: loads A then B from one stream,
// pulses the multiplier start, captures its result and streams it out.
// Optional s_last framing check: define TAU_GEMM_HOST_LAST_CHK_EN.
module tau_gemm_host
   import tau_gemm_pkg::*;
#(
   parameter int DIM      = 16,
   parameter int WIDTH    = 8,
   parameter int OUT_BITS = 2 * WIDTH
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [WIDTH-1:0]             s_data,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [OUT_BITS-1:0]          m_data,
   output logic                         m_last,
   output logic [DIM*DIM*WIDTH-1:0]     mat_a,
   output logic [DIM*DIM*WIDTH-1:0]     mat_b,
   output logic                         mul_valid,
   input  logic [DIM*DIM*OUT_BITS-1:0]  mul_out,
   input  logic                         mul_finished,
   output logic                         busy,
   output logic                         err
);

   localparam int IW = idx_w(DIM);
   localparam int RW = rc_w(DIM);

   state_t state_q, state_d;
   logic   rdy_q;

   logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    a_q;
   logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    b_q;
   logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] res_q;

   logic          s_fire;
   logic          m_fire;
   logic          frame_err;
   logic          cnt_last;
   logic [IW-1:0] idx;
   logic [RW-1:0] row;
   logic [RW-1:0] col;

   tau_gemm_idx_cnt #(.DIM(DIM)) u_idx_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (frame_err),
      .inc     (s_fire | m_fire),
      .idx     (idx),
      .row     (row),
      .col     (col),
      .last    (cnt_last)
   );

   // rdy_q keeps s_ready low until the first clock after reset release.
   assign s_ready   = rdy_q && (state_q == LOAD_A || state_q == LOAD_B);
   assign s_fire    = s_valid && s_ready;
   assign m_valid   = (state_q == DRAIN);
   assign m_fire    = m_valid && m_ready;
   assign m_data    = m_valid ? res_q[row][col] : '0;
   assign m_last    = m_valid && cnt_last;
   assign mul_valid = (state_q == ISSUE);
   assign busy      = !(state_q == LOAD_A && idx == '0);
   assign mat_a     = a_q;
   assign mat_b     = b_q;

`ifdef TAU_GEMM_HOST_LAST_CHK_EN
   logic err_q;

   // s_last must be high exactly on the final B beat.
   assign frame_err = s_fire && (s_last != (state_q == LOAD_B && cnt_last));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (frame_err) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_s_last;

   assign unused_s_last = s_last;
   assign frame_err     = 1'b0;
   assign err           = 1'b0;
`endif

   // NOTE: next state defaults to current state first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD_A:  if (s_fire && cnt_last) state_d = LOAD_B;
         LOAD_B:  if (s_fire && cnt_last) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (mul_finished) state_d = DRAIN;
         DRAIN:   if (m_fire && cnt_last) state_d = LOAD_A;
         default: state_d = LOAD_A;
      endcase
      if (frame_err) state_d = LOAD_A;
   end

   // NOTE: operand and result arrays are reset because they drive mat_a/mat_b/m_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LOAD_A;
         rdy_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         if (s_fire && state_q == LOAD_A) a_q[row][col] <= s_data;
         if (s_fire && state_q == LOAD_B) b_q[row][col] <= s_data;
         if (state_q == WAIT && mul_finished) res_q <= mul_out;
      end
   end

endmodule
